uart_price_parser: RTL
======================

# uart_price_parser

Byte-level frame parser that consumes the received-byte stream of the UART receiver and extracts fixed-length price quotes for the arbitrage engine. It hunts for a sync byte, then collects an instrument/exchange ID, a big-endian price field and an optional XOR checksum. A validated quote is presented as a single-cycle strobe with held data. Inter-byte timeouts and line BREAKs abort partial frames so the parser always resynchronises.

## Interface
- `PRICE_BYTES`, 4: number of price bytes per frame (1..8).
- `SYNC_BYTE`, 8'hAA: frame start marker.
- `TIMEOUT_CYCLES`, 43400: max clk cycles between bytes inside a frame; about 10 byte times at 115200 baud / 50 MHz.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `rx_break`  in  1  BREAK flag, qualified by `rx_valid`.
- `out_valid`  out  1  one-cycle strobe: a validated quote is on `out_id`/`out_price`.
- `out_id`  out  8  ID byte of the last valid frame.
- `out_price`  out  8*PRICE_BYTES  price of the last valid frame; the first received byte is the MSB.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout aborted a frame.

## Operation
- Frame: `SYNC_BYTE`, ID, P[0..PRICE_BYTES-1], CHK. CHK is the XOR of ID and all price bytes; SYNC is excluded.
- FSM states:
  - HUNT: on `rx_valid` with `rx_data==SYNC_BYTE` and no break, go to GET_ID. Any other byte is dropped silently.
  - GET_ID: latch ID into a shadow register, seed the running XOR with ID, go to GET_PRICE.
  - GET_PRICE: shift each byte into the shadow price (`shadow <= {shadow, byte}`), XOR it into the running XOR, and increment the byte counter. After byte `PRICE_BYTES-1`, go to GET_CHK.
  - GET_CHK: compare the byte with the running XOR.
    - Match: copy the shadow registers to `out_id`/`out_price` and pulse `out_valid`.
    - Mismatch: pulse `err_chk`; outputs are unchanged.
    - Either way, go to HUNT.
- A byte equal to `SYNC_BYTE` outside HUNT is treated as data; there is no mid-frame resync.
- `rx_valid && rx_break` in any state goes to HUNT. No error pulse, no output update.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared in HUNT and on every `rx_valid`; increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` with no `rx_valid` that cycle, go to HUNT and pulse `err_timeout`.
- Simultaneous events:
  - `rx_valid` on the timeout-expiry cycle: the byte wins and no timeout is raised.
  - Break on a GET_CHK byte: break wins; neither `out_valid` nor `err_chk` fires.
- The byte counter is a 3-bit down-counter, loaded with `PRICE_BYTES-1` in GET_ID.

## Timing
- All outputs are registered.
- Reset values: `out_valid=0`, `err_chk=0`, `err_timeout=0`, `out_id=0`, `out_price=0`. FSM in HUNT; counters, XOR and shadow registers at 0.
- `out_valid`/`err_chk` assert on the clk edge after the cycle in which the CHK byte's `rx_valid` is sampled (1-cycle latency), and stay high exactly one cycle.
- `out_id`/`out_price` change only together with `out_valid` and hold until the next valid frame.
- `err_timeout` asserts one cycle after the expiry cycle, for one cycle.
- Back-to-back frames are allowed: a SYNC byte can arrive on the cycle `out_valid` is high and is accepted, because the FSM is already in HUNT.
- Reset mid-frame discards the partial frame. Outputs return to reset values on the next edge.
- There is no back-pressure. The consumer must accept `out_valid` in the cycle it is high.

## Configuration
- `PARSER_CHECKSUM_EN` defined:
  - Frame includes CHK and GET_CHK exists, as described above.
- `PARSER_CHECKSUM_EN` undefined:
  - No GET_CHK state and no XOR logic. `err_chk` is tied to 0.
  - After the last price byte, the FSM copies the shadow registers to the outputs, pulses `out_valid` (1-cycle latency from that byte), and returns to HUNT.
  - Frame length is `2+PRICE_BYTES` bytes.

## Test plan
- Checksum enabled, defaults. Send bytes AA 07 00 01 86 A0 20, each 4340 cycles apart -> one `out_valid` pulse, `out_id=8'h07`, `out_price=32'h000186A0`. Check the pulse lands 1 cycle after the final `rx_valid`.
- Same frame with CHK=21 -> `err_chk` pulses once, `out_valid` stays 0, outputs keep their previous values. A following correct frame is still parsed.
- Send AA 07 00, then wait 43400 cycles -> `err_timeout` pulses once. Then AA 05 00 00 00 0A 0F -> `out_id=05`, `out_price=32'h0000000A`.
- Send 55 AA AA 01 02 03 04 AA ... (SYNC as ID): ID=AA, price=01020304, CHK=AA^01^02^03^04=AE -> valid frame. The leading 55 is ignored.
- Send AA 07 00 01, then `rx_valid` with `rx_break=1` and `rx_data=00` -> no pulses, FSM in HUNT. Assert `resetn=0` mid-frame -> all outputs are 0 on the next edge.
- With `PARSER_CHECKSUM_EN` undefined: send AA 07 00 01 86 A0 -> `out_valid` 1 cycle after A0, `out_price=32'h000186A0`, `err_chk` never asserts.

Source files
------------

// File: rtl/uart_price_parser.sv
// Frame parser for the UART byte stream: SYNC, ID, big-endian price, optional XOR checksum.
// Define PARSER_CHECKSUM_EN to include the CHK byte and its verification.
module uart_price_parser #(
  parameter int         PRICE_BYTES    = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 43400
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_break,
  output logic                     out_valid,
  output logic [7:0]               out_id,
  output logic [8*PRICE_BYTES-1:0] out_price,
  output logic                     err_chk,
  output logic                     err_timeout
);

  localparam int               PRICE_W  = 8 * PRICE_BYTES;
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]       CNT_LOAD = 3'(PRICE_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef PARSER_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT, GET_ID, GET_PRICE, GET_CHK} state_t;
`else
  typedef enum logic [1:0] {HUNT, GET_ID, GET_PRICE} state_t;
`endif

  state_t               state, state_next;
  logic [7:0]           shadow_id;
  logic [PRICE_W-1:0]   shadow_price;
  logic [PRICE_W-1:0]   price_shifted;
  logic [PRICE_W-1:0]   commit_price;
  logic [2:0]           byte_cnt;
  logic [TMO_W-1:0]     tmo_cnt;

  logic brk_abort;
  logic tmo_hit;
  logic load_id;
  logic shift_price;
  logic commit;
  logic tmo_fire;

  assign brk_abort     = rx_valid && rx_break;
  assign tmo_hit       = (state != HUNT) && !rx_valid && (tmo_cnt == TMO_LAST);
  assign price_shifted = (shadow_price << 8) | PRICE_W'(rx_data);

`ifdef PARSER_CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       chk_fail;

  assign commit_price = shadow_price;
`else
  // Without a CHK byte the last price byte is committed in the same cycle it arrives.
  assign commit_price = price_shifted;
  assign err_chk      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= HUNT;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_id     = 1'b0;
    shift_price = 1'b0;
    commit      = 1'b0;
    tmo_fire    = 1'b0;
`ifdef PARSER_CHECKSUM_EN
    chk_fail    = 1'b0;
`endif
    // A break outranks everything, and any byte (even on the expiry cycle) beats the timeout.
    if (brk_abort) begin
      state_next = HUNT;
    end else if (tmo_hit) begin
      state_next = HUNT;
      tmo_fire   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        HUNT: begin
          if (rx_data == SYNC_BYTE) state_next = GET_ID;
        end
        GET_ID: begin
          load_id    = 1'b1;
          state_next = GET_PRICE;
        end
        GET_PRICE: begin
          shift_price = 1'b1;
          if (byte_cnt == 3'd0) begin
`ifdef PARSER_CHECKSUM_EN
            state_next = GET_CHK;
`else
            commit     = 1'b1;
            state_next = HUNT;
`endif
          end
        end
`ifdef PARSER_CHECKSUM_EN
        GET_CHK: begin
          state_next = HUNT;
          if (rx_data == xor_acc) commit   = 1'b1;
          else                    chk_fail = 1'b1;
        end
`endif
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || (state == HUNT) || rx_valid || tmo_fire) tmo_cnt <= '0;
    else                                                     tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shadow_id    <= 8'd0;
      shadow_price <= '0;
      byte_cnt     <= 3'd0;
      out_valid    <= 1'b0;
      err_timeout  <= 1'b0;
      out_id       <= 8'd0;
      out_price    <= '0;
    end else begin
      out_valid   <= commit;
      err_timeout <= tmo_fire;
      if (load_id) begin
        shadow_id <= rx_data;
        byte_cnt  <= CNT_LOAD;
      end
      if (shift_price) begin
        shadow_price <= price_shifted;
        if (byte_cnt != 3'd0) byte_cnt <= byte_cnt - 3'd1;
      end
      if (commit) begin
        out_id    <= shadow_id;
        out_price <= commit_price;
      end
    end
  end

`ifdef PARSER_CHECKSUM_EN
  // Running XOR is seeded by the ID so the SYNC byte never contributes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xor_acc <= 8'd0;
      err_chk <= 1'b0;
    end else begin
      err_chk <= chk_fail;
      if (load_id)          xor_acc <= rx_data;
      else if (shift_price) xor_acc <= xor_acc ^ rx_data;
    end
  end
`endif

endmodule
